// File: rtl/morse_msg_builder_pkg.sv
// Morse character table and encoded-length helpers shared by the message builder
// and its serializer. Entry = {elem_cnt[2:0], pattern[4:0]}, pattern LSB is the first element, 1 = dash.
package morse_pkg;

  localparam logic [5:0] CH_A     = 6'd0;
  localparam logic [5:0] CH_0     = 6'd26;
  localparam logic [5:0] CH_SPACE = 6'd36;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_FROZEN
  } state_t;

  localparam logic [7:0] MORSE_TBL [0:36] = '{
    8'h42, 8'h81, 8'h85, 8'h61, 8'h20, 8'h84, 8'h63, 8'h80, 8'h40, 8'h8E,  // A-J
    8'h65, 8'h82, 8'h43, 8'h41, 8'h67, 8'h86, 8'h8B, 8'h62, 8'h60, 8'h21,  // K-T
    8'h64, 8'h88, 8'h66, 8'h89, 8'h8D, 8'h83,                              // U-Z
    8'hBF, 8'hBE, 8'hBC, 8'hB8, 8'hB0, 8'hA0, 8'hA1, 8'hA3, 8'hA7, 8'hAF,  // 0-9
    8'h00                                                                  // space
  };

  function automatic logic [7:0] morse_entry(input logic [5:0] code);
    logic [7:0] ent;
    ent = 8'h00;
    if (code <= CH_SPACE) ent = MORSE_TBL[code];
    return ent;
  endfunction

  // Invalid codes report length 0.
  function automatic logic [4:0] morse_len(input logic [5:0] code);
    logic [7:0] ent;
    logic [4:0] len;
    ent = morse_entry(code);
    len = 5'd0;
    if (code == CH_SPACE) begin
      len = 5'd4;
    end else if (code < CH_SPACE) begin
      for (int i = 0; i < 5; i++) begin
        if (3'(i) < ent[7:5]) len = len + (ent[i] ? 5'd4 : 5'd2);
      end
      len = len + 5'd2;
    end
    return len;
  endfunction

endpackage

// File: rtl/morse_msg_builder_if.sv
// Character handshake and message/playback status bundle of the Morse message builder.
// master = character source / playback side, slave = the builder.
interface morse_msg_builder_if #(
  parameter int MSG_W  = 136,
  parameter int CODE_W = 6
);
  logic [CODE_W-1:0] char_code;
  logic              char_valid;
  logic              char_ready;
  logic              commit;
  logic              clear;
  logic [MSG_W-1:0]  message;
  logic              send;
  logic [7:0]        bit_count;
  logic              busy;
  logic              overflow;

  modport master (
    output char_code, char_valid, commit, clear,
    input  char_ready, message, send, bit_count, busy, overflow
  );

  modport slave (
    input  char_code, char_valid, commit, clear,
    output char_ready, message, send, bit_count, busy, overflow
  );
endinterface

// File: rtl/morse_msg_builder_serializer.sv
// Expands one character's element pattern into its on/off bit stream, one bit per cycle.
// First bit is presented the cycle after load; o_last flags the final bit; no backpressure.
module morse_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [4:0] i_pattern,
  input  logic [2:0] i_elem_cnt,
  input  logic [4:0] i_len,
  output logic       o_bit,
  output logic       o_last
);

  logic [4:0] r_pat;
  logic [2:0] r_elems;
  logic [1:0] r_pos;
  logic [4:0] r_rem;
  logic       r_active;
  logic       w_elem_end;

  // A dot is 1,0 and a dash is 1,1,1,0; the trailing 0 closes the element.
  assign w_elem_end = r_pat[0] ? (r_pos == 2'd3) : (r_pos == 2'd1);
  assign o_bit      = r_active && (r_elems != 3'd0) && !w_elem_end;
  assign o_last     = r_active && (r_rem == 5'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat    <= '0;
      r_elems  <= '0;
      r_pos    <= '0;
      r_rem    <= '0;
      r_active <= 1'b0;
    end else if (i_clear) begin
      r_active <= 1'b0;
    end else if (i_load) begin
      r_pat    <= i_pattern;
      r_elems  <= i_elem_cnt;
      r_pos    <= 2'd0;
      r_rem    <= i_len;
      r_active <= (i_len != 5'd0);
    end else if (r_active) begin
      r_rem <= r_rem - 5'd1;
      if (r_rem == 5'd1) r_active <= 1'b0;
      // Once all elements are out, the remaining bits are the zero gap.
      if (r_elems != 3'd0) begin
        if (w_elem_end) begin
          r_pos   <= 2'd0;
          r_pat   <= r_pat >> 1;
          r_elems <= r_elems - 3'd1;
        end else begin
          r_pos <= r_pos + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/morse_msg_builder.sv
// Builds a Morse on/off message buffer from character codes and freezes it for playback on commit.
// Accept at T -> bits written T+1..T+len; char_ready low while emitting, frozen, or on commit/clear.
module morse_msg_builder
  import morse_pkg::*;
#(
  parameter int MSG_W  = 136,
  parameter int CODE_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  morse_msg_builder_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nx;
  logic [MSG_W-1:0] r_message;
  logic [7:0]       r_bit_count;
  logic             r_overflow;
  logic             r_pending;

  logic             w_ready;
  logic             w_code_ok;
  logic [7:0]       w_ent;
  logic [4:0]       w_len;
  logic             w_fits;
  logic             w_load;
  logic             w_drop_ovf;
  logic             w_ser_bit;
  logic             w_ser_last;

  assign w_ready    = (r_state == ST_IDLE) && !bus.commit && !bus.clear;
  assign w_code_ok  = (bus.char_code <= CH_SPACE);
  assign w_ent      = morse_entry(bus.char_code);
  assign w_len      = morse_len(bus.char_code);
  assign w_fits     = ({1'b0, r_bit_count} + {4'd0, w_len}) <= 9'(MSG_W);
  assign w_load     = bus.char_valid && w_ready && w_code_ok && w_fits;
  assign w_drop_ovf = bus.char_valid && w_ready && w_code_ok && !w_fits;

  morse_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (bus.clear),
    .i_load     (w_load),
    .i_pattern  (w_ent[4:0]),
    .i_elem_cnt (w_ent[7:5]),
    .i_len      (w_len),
    .o_bit      (w_ser_bit),
    .o_last     (w_ser_last)
  );

  always_comb begin
    w_state_nx = r_state;
    if (bus.clear) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.commit && (r_bit_count != 8'd0)) w_state_nx = ST_FROZEN;
          else if (w_load)                         w_state_nx = ST_EMIT;
        end
        // A pending commit replaces the IDLE cycle after the last bit.
        ST_EMIT: begin
          if (w_ser_last) w_state_nx = (r_pending || bus.commit) ? ST_FROZEN : ST_IDLE;
        end
        ST_FROZEN: w_state_nx = ST_FROZEN;
        default:   w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_message   <= '0;
      r_bit_count <= '0;
      r_overflow  <= 1'b0;
      r_pending   <= 1'b0;
    end else if (bus.clear) begin
      r_message   <= '0;
      r_bit_count <= '0;
      r_overflow  <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      if ((r_state == ST_EMIT) && (r_bit_count < 8'(MSG_W))) begin
        r_message[r_bit_count] <= w_ser_bit;
        r_bit_count            <= r_bit_count + 8'd1;
      end
      if (r_state == ST_EMIT) begin
        if (w_ser_last)      r_pending <= 1'b0;
        else if (bus.commit) r_pending <= 1'b1;
      end
      if (w_drop_ovf) r_overflow <= 1'b1;
    end
  end

  assign bus.char_ready = w_ready;
  assign bus.message    = r_message;
  assign bus.bit_count  = r_bit_count;
  assign bus.overflow   = r_overflow;
  assign bus.send       = (r_state == ST_FROZEN);
  assign bus.busy       = (r_state == ST_EMIT);

endmodule

// File: tb/tb_morse_msg_builder.sv
// Self-checking bench for morse_msg_builder: directed cases plus randomized character streams
// compared against a dot/dash string model of the Morse alphabet.
module tb_morse_msg_builder;

  localparam int MSG_W = 136;

  logic clk;
  logic rst_n;

  morse_msg_builder_if #(.MSG_W(MSG_W), .CODE_W(6)) bus ();

  morse_msg_builder #(.MSG_W(MSG_W), .CODE_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  logic [MSG_W-1:0] exp_msg;
  int               exp_cnt;
  logic             exp_ovf;

  string MORSE [0:35] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic string encode(input int code);
    string s;
    string m;
    s = "";
    if (code == 36) return "0000";
    if (code > 36) return "";
    m = MORSE[code];
    for (int i = 0; i < m.len(); i++) begin
      if (m.substr(i, i) == "-") s = {s, "1110"};
      else                       s = {s, "10"};
    end
    return {s, "00"};
  endfunction

  function automatic void model_clear();
    exp_msg = '0;
    exp_cnt = 0;
    exp_ovf = 1'b0;
  endfunction

  // Returns the number of cycles the block should be busy for this character.
  function automatic int model_apply(input int code);
    string s;
    s = encode(code);
    if (s.len() == 0) return 0;
    if (exp_cnt + s.len() > MSG_W) begin
      exp_ovf = 1'b1;
      return 0;
    end
    for (int i = 0; i < s.len(); i++) exp_msg[exp_cnt + i] = (s.substr(i, i) == "1");
    exp_cnt += s.len();
    return s.len();
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_bit_count"}, 256'(bus.bit_count), 256'(exp_cnt));
    check({tag, "_message"},   256'(bus.message),   256'(exp_msg));
    check({tag, "_overflow"},  256'(bus.overflow),  256'(exp_ovf));
  endtask

  task automatic send_char(input int code, input string tag);
    int exp_n;
    int n;
    exp_n = model_apply(code);
    @(negedge clk);
    bus.char_valid = 1'b1;
    bus.char_code  = 6'(code);
    @(negedge clk);
    bus.char_valid = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 256'(n), 256'(exp_n));
    check_state(tag);
    check({tag, "_ready"}, 256'(bus.char_ready), 256'(1));
  endtask

  task automatic pulse_clear(input logic with_commit);
    @(negedge clk);
    bus.clear  = 1'b1;
    bus.commit = with_commit;
    @(negedge clk);
    bus.clear  = 1'b0;
    bus.commit = 1'b0;
    model_clear();
  endtask

  task automatic commit_idle(input string tag);
    logic exp_send;
    exp_send = (exp_cnt != 0);
    @(negedge clk);
    bus.commit = 1'b1;
    #1;
    check({tag, "_ready_on_commit"}, 256'(bus.char_ready), 256'(0));
    @(negedge clk);
    bus.commit = 1'b0;
    check({tag, "_send"}, 256'(bus.send), 256'(exp_send));
    check_state(tag);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    model_clear();
    rst_n          = 1'b0;
    bus.char_code  = '0;
    bus.char_valid = 1'b0;
    bus.commit     = 1'b0;
    bus.clear      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_send",  256'(bus.send),       256'(0));
    check("rst_busy",  256'(bus.busy),       256'(0));
    check("rst_ready", 256'(bus.char_ready), 256'(1));
    check_state("rst");

    // Single dot 'E'.
    send_char(4, "E");
    check("E_low_bits", 256'(bus.message[3:0]), 256'(4'b0001));

    // 'A' then a word space.
    pulse_clear(1'b0);
    send_char(0, "A");
    check("A_low_bits", 256'(bus.message[7:0]), 256'(8'b0001_1101));
    send_char(36, "SPACE");
    check("SPACE_count", 256'(bus.bit_count), 256'(12));

    // Commit from IDLE, then attempts while frozen.
    commit_idle("commit_idle");
    @(negedge clk);
    bus.char_valid = 1'b1;
    bus.char_code  = 6'd4;
    #1;
    check("frozen_ready", 256'(bus.char_ready), 256'(0));
    bus.commit = 1'b1;
    @(negedge clk);
    bus.char_valid = 1'b0;
    bus.commit     = 1'b0;
    check("frozen_send", 256'(bus.send), 256'(1));
    check_state("frozen_hold");
    pulse_clear(1'b1);
    check("clear_send", 256'(bus.send), 256'(0));
    check_state("clear_frozen");

    // Commit with an empty buffer is ignored.
    commit_idle("commit_empty");

    // Commit latched while emitting 'T'.
    void'(model_apply(19));
    @(negedge clk);
    bus.char_valid = 1'b1;
    bus.char_code  = 6'd19;
    @(negedge clk);
    bus.char_valid = 1'b0;
    bus.commit     = 1'b1;
    @(negedge clk);
    bus.commit = 1'b0;
    check("T_send_during_emit", 256'(bus.send), 256'(0));
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("T_send_after_last", 256'(bus.send), 256'(1));
    check("T_ready_frozen", 256'(bus.char_ready), 256'(0));
    check("T_low_bits", 256'(bus.message[5:0]), 256'(6'b000111));
    check_state("T_commit");
    pulse_clear(1'b0);

    // Overflow: six '0' fill 132 bits, a seventh is dropped, 'E' fills exactly.
    for (int i = 0; i < 6; i++) send_char(26, "zero_fill");
    check("fill_count", 256'(bus.bit_count), 256'(132));
    send_char(26, "zero_drop");
    check("drop_overflow", 256'(bus.overflow), 256'(1));
    send_char(4, "E_exact_fit");
    check("exact_fit_count", 256'(bus.bit_count), 256'(136));
    send_char(4, "E_full");
    pulse_clear(1'b0);
    send_char(50, "invalid");

    // Asynchronous reset in the middle of a character.
    @(negedge clk);
    bus.char_valid = 1'b1;
    bus.char_code  = 6'd26;
    @(negedge clk);
    bus.char_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("arst_busy", 256'(bus.busy), 256'(0));
    check("arst_send", 256'(bus.send), 256'(0));
    check_state("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", 256'(bus.char_ready), 256'(1));
    send_char(13, "after_arst");

    // Randomized character streams.
    for (int r = 0; r < 5; r++) begin
      int nchars;
      int code;
      pulse_clear(1'b0);
      nchars = $urandom_range(8, 30);
      for (int c = 0; c < nchars; c++) begin
        if ($urandom_range(0, 9) == 0) code = $urandom_range(37, 63);
        else                           code = $urandom_range(0, 36);
        send_char(code, "rand");
      end
      commit_idle("rand_commit");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
